// File: rtl/st2mm_tx_arb.sv
// st2mm_tx_arb: packet-locked arbiter sharing one CSR-domain TX AXI-S path between NUM_CH TLP sources.
// Latency: 1 idle cycle per arbitration (grant registered in IDLE), then a 0-cycle combinational data path.
// Backpressure: m_tready passes straight through to the granted source only; all other sources see tready=0.
//
// Sources: ch0 = MMIO completions, ch1 = MCTP VDM, ch2 = MSI-X.
// Arbitration is fixed priority (lowest index wins). A channel that has waited STARVE_LIMIT cycles
// is promoted ahead of the non-starved channels.
//
// Optional build macro: ST2MM_TX_ARB_STATS_EN enables the per-channel packet counters on pkt_cnt.
// Without it, pkt_cnt is tied to zero.
//
// Ports:
//   clk, rst                     CSR-domain clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tdata/   per-channel AXI-S sinks, packed with channel i at slice i
//   s_tkeep/s_tlast/s_tuser
//   m_tvalid/m_tready/m_tdata/   shared AXI-S source towards the TX CDC FIFO
//   m_tkeep/m_tlast/m_tuser
//   grant_id                     channel currently owning the output
//   busy                         1 while a packet is being transferred
//   pkt_cnt                      per-channel accepted-packet counters, 32 bits each
module st2mm_tx_arb #(
  parameter int NUM_CH       = 3,
  parameter int TDATA_W      = 512,
  parameter int TUSER_W      = 10,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             s_tvalid,
  output logic [NUM_CH-1:0]             s_tready,
  input  logic [NUM_CH*TDATA_W-1:0]     s_tdata,
  input  logic [NUM_CH*TDATA_W/8-1:0]   s_tkeep,
  input  logic [NUM_CH-1:0]             s_tlast,
  input  logic [NUM_CH*TUSER_W-1:0]     s_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [TDATA_W-1:0]            m_tdata,
  output logic [TDATA_W/8-1:0]          m_tkeep,
  output logic                          m_tlast,
  output logic [TUSER_W-1:0]            m_tuser,
  output logic [$clog2(NUM_CH)-1:0]     grant_id,
  output logic                          busy,
  output logic [NUM_CH*32-1:0]          pkt_cnt
);

  localparam int GW = $clog2(NUM_CH);
  localparam int KW = TDATA_W / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]        state;
  logic [CW-1:0]     wait_cnt [NUM_CH];
  logic [NUM_CH-1:0] starved;
  logic [GW-1:0]     winner;
  logic              win_evt;
  logic              last_acc;

  // Starved channels pre-empt the plain priority order; within each set the lowest index wins.
  // Scanning from high to low lets the lowest matching index overwrite the others.
  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      starved[i] = s_tvalid[i] && (wait_cnt[i] >= CW'(STARVE_LIMIT));
    end
    winner = '0;
    if (|starved) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (starved[i]) winner = GW'(i);
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (s_tvalid[i]) winner = GW'(i);
      end
    end
  end

  assign win_evt = (state == ST_IDLE) && (|s_tvalid);
  assign busy    = (state == ST_XFER);

  // Combinational mux of the granted channel. Outside XFER everything is held at its reset value.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tuser  = '0;
    s_tready = '0;
    if (state == ST_XFER) begin
      m_tvalid           = s_tvalid[grant_id];
      m_tdata            = s_tdata[grant_id*TDATA_W +: TDATA_W];
      m_tkeep            = s_tkeep[grant_id*KW +: KW];
      m_tlast            = s_tlast[grant_id];
      m_tuser            = s_tuser[grant_id*TUSER_W +: TUSER_W];
      s_tready[grant_id] = m_tready;
    end
  end

  assign last_acc = m_tvalid && m_tready && m_tlast;

  // The grant is only released on the accepted tlast beat, so a source that stalls mid-packet
  // keeps ownership until it finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_id <= '0;
    end else if (state == ST_IDLE) begin
      if (win_evt) begin
        grant_id <= winner;
        state    <= ST_XFER;
      end
    end else begin
      if (last_acc) state <= ST_IDLE;
    end
  end

  // Age counters run in both states; a win or a dropped tvalid restarts the wait.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        wait_cnt[i] <= '0;
      end else if (!s_tvalid[i] || (win_evt && (winner == GW'(i)))) begin
        wait_cnt[i] <= '0;
      end else if (wait_cnt[i] != CW'(STARVE_LIMIT)) begin
        wait_cnt[i] <= wait_cnt[i] + CW'(1);
      end
    end
  end

`ifdef ST2MM_TX_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_CH];

  // Free-running wrap-around counters of accepted packets per channel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (last_acc && (grant_id == GW'(i))) begin
        cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pkt_cnt[i*32 +: 32] = cnt_q[i];
    end
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_st2mm_tx_arb.sv
// tb_st2mm_tx_arb: directed bench for st2mm_tx_arb (3 channels, 32-bit data, STARVE_LIMIT=4).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Expected packet counts depend on whether ST2MM_TX_ARB_STATS_EN is defined for the build.
module tb_st2mm_tx_arb;

  localparam int NUM_CH  = 3;
  localparam int TDATA_W = 32;
  localparam int TUSER_W = 10;
  localparam int KW      = TDATA_W / 8;

`ifdef ST2MM_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                        clk;
  logic                        rst;
  logic [NUM_CH-1:0]           s_tvalid;
  logic [NUM_CH-1:0]           s_tready;
  logic [NUM_CH*TDATA_W-1:0]   s_tdata;
  logic [NUM_CH*KW-1:0]        s_tkeep;
  logic [NUM_CH-1:0]           s_tlast;
  logic [NUM_CH*TUSER_W-1:0]   s_tuser;
  logic                        m_tvalid;
  logic                        m_tready;
  logic [TDATA_W-1:0]          m_tdata;
  logic [KW-1:0]               m_tkeep;
  logic                        m_tlast;
  logic [TUSER_W-1:0]          m_tuser;
  logic [1:0]                  grant_id;
  logic                        busy;
  logic [NUM_CH*32-1:0]        pkt_cnt;

  logic [TDATA_W-1:0] dat [NUM_CH];
  logic [KW-1:0]      kep [NUM_CH];
  logic [TUSER_W-1:0] usr [NUM_CH];
  logic [NUM_CH-1:0]  vld;
  logic [NUM_CH-1:0]  lst;

  int checks = 0;
  int passes = 0;

  st2mm_tx_arb #(
    .NUM_CH      (NUM_CH),
    .TDATA_W     (TDATA_W),
    .TUSER_W     (TUSER_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .s_tuser (s_tuser),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tuser (m_tuser),
    .grant_id(grant_id),
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    s_tvalid = vld;
    s_tlast  = lst;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_tdata[i*TDATA_W +: TDATA_W] = dat[i];
      s_tkeep[i*KW +: KW]           = kep[i];
      s_tuser[i*TUSER_W +: TUSER_W] = usr[i];
    end
  end

  function automatic logic [TDATA_W-1:0] edat(input int ch, input int beat);
    return {8'(ch), 8'(beat), 16'hC0DE};
  endfunction

  function automatic logic [95:0] exp_pkt(input int c0, input int c1, input int c2);
    return STATS ? {32'(c2), 32'(c1), 32'(c0)} : 96'd0;
  endfunction

  task automatic drive(input int ch, input logic v, input int beat, input logic l);
    vld[ch] = v;
    lst[ch] = l;
    dat[ch] = edat(ch, beat);
    kep[ch] = KW'(ch + 1);
    usr[ch] = TUSER_W'(ch * 16 + beat);
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full output beat: {m_tvalid, grant_id, m_tlast, m_tkeep, m_tuser, m_tdata}.
  task automatic chk_beat(input string tag, input int ch, input int beat, input logic l);
    chk(tag, {m_tvalid, grant_id, m_tlast, m_tkeep, m_tuser, m_tdata},
        {1'b1, 2'(ch), l, KW'(ch + 1), TUSER_W'(ch * 16 + beat), edat(ch, beat)});
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {busy, m_tvalid, s_tready}, '0);
  endtask

  task automatic pkt1(input string tag, input int ch);
    cyc; drive(ch, 1'b1, 0, 1'b1); #1;
    cyc; #1; chk_beat(tag, ch, 0, 1'b1);
    cyc; drive(ch, 1'b0, 0, 1'b0); #1; chk_idle({tag, "_idle"});
  endtask

  initial begin
    rst      = 1'b1;
    m_tready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) drive(i, 1'b0, 0, 1'b0);
    repeat (2) cyc;
    #1;
    chk("reset_state", {busy, m_tvalid, s_tready, grant_id, pkt_cnt}, '0);
    rst = 1'b0;

    // 1: 3-beat ch0 packet with m_tready held high.
    cyc; m_tready = 1'b1; drive(0, 1'b1, 0, 1'b0); #1; chk_idle("t1_arb_bubble");
    cyc; #1; chk_beat("t1_beat0", 0, 0, 1'b0); chk("t1_tready", s_tready, 3'b001);
    cyc; drive(0, 1'b1, 1, 1'b0); #1; chk_beat("t1_beat1", 0, 1, 1'b0);
    cyc; drive(0, 1'b1, 2, 1'b1); #1; chk_beat("t1_beat2", 0, 2, 1'b1);
    cyc; drive(0, 1'b0, 0, 1'b0); #1; chk_idle("t1_idle_after");

    // 2: ch0 and ch2 request together; ch0 first, ch2 after one bubble.
    cyc; drive(0, 1'b1, 0, 1'b1); drive(2, 1'b1, 0, 1'b1); #1; chk_idle("t2_arb_bubble");
    cyc; #1; chk_beat("t2_ch0_first", 0, 0, 1'b1);
    cyc; drive(0, 1'b0, 0, 1'b0); #1; chk_idle("t2_bubble");
    cyc; #1; chk_beat("t2_ch2_second", 2, 0, 1'b1); chk("t2_tready", s_tready, 3'b100);
    cyc; drive(2, 1'b0, 0, 1'b0); #1; chk_idle("t2_idle_after");

    // 3: ch0 keeps sending 1-beat packets; ch1 waits until its age reaches 4, then wins.
    cyc; drive(0, 1'b1, 0, 1'b1); drive(1, 1'b1, 0, 1'b1); #1;
    cyc; #1; chk_beat("t3_ch0_a", 0, 0, 1'b1);
    cyc; #1; chk_idle("t3_bubble_a");
    cyc; #1; chk_beat("t3_ch0_b", 0, 0, 1'b1);
    cyc; #1; chk_idle("t3_bubble_b");
    cyc; #1; chk_beat("t3_ch1_promoted", 1, 0, 1'b1); chk("t3_tready", s_tready, 3'b010);
    cyc; drive(0, 1'b0, 0, 1'b0); drive(1, 1'b0, 0, 1'b0); #1; chk_idle("t3_idle_after");

    // 4: 2-beat ch1 packet with m_tready 1,0,0,1.
    cyc; drive(1, 1'b1, 0, 1'b0); #1;
    cyc; #1; chk_beat("t4_beat0", 1, 0, 1'b0); chk("t4_tready_go0", s_tready, 3'b010);
    cyc; drive(1, 1'b1, 1, 1'b1); m_tready = 1'b0; #1;
    chk_beat("t4_stall1", 1, 1, 1'b1); chk("t4_tready_stall1", s_tready, 3'b000);
    cyc; #1; chk_beat("t4_stall2", 1, 1, 1'b1); chk("t4_tready_stall2", s_tready, 3'b000);
    cyc; m_tready = 1'b1; #1; chk_beat("t4_beat1", 1, 1, 1'b1); chk("t4_tready_go1", s_tready, 3'b010);
    cyc; drive(1, 1'b0, 0, 1'b0); #1; chk_idle("t4_idle_after");
    chk("pkt_cnt_pre_reset", pkt_cnt, exp_pkt(4, 2, 1));

    // 5: reset during beat 2 of a 4-beat ch2 packet.
    cyc; drive(2, 1'b1, 0, 1'b0); #1;
    cyc; #1; chk_beat("t5_beat0", 2, 0, 1'b0);
    cyc; drive(2, 1'b1, 1, 1'b0); rst = 1'b1; #1; chk_beat("t5_beat1", 2, 1, 1'b0);
    cyc; rst = 1'b0; drive(2, 1'b0, 0, 1'b0); #1;
    chk("t5_after_reset", {busy, m_tvalid, s_tready, grant_id}, '0);
    chk("t5_pkt_cnt_clear", pkt_cnt, '0);

    // 6: 5 packets on ch0 and 2 on ch2.
    for (int n = 0; n < 5; n++) pkt1("t6_ch0", 0);
    for (int n = 0; n < 2; n++) pkt1("t6_ch2", 2);
    chk("t6_pkt_cnt", pkt_cnt, exp_pkt(5, 0, 2));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
